// File: rtl/uart_pkg.sv
// Shared encodings and helpers for the FIFO-fed UART transmitter.
package uart_pkg;

  localparam int unsigned DEFAULT_CLKS_PER_BIT = 868;

  localparam int unsigned STATE_W = 3;
  typedef logic [STATE_W-1:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_FETCH  = 3'd1;
  localparam state_t ST_LOAD   = 3'd2;
  localparam state_t ST_START  = 3'd3;
  localparam state_t ST_DATA   = 3'd4;
  localparam state_t ST_PARITY = 3'd5;
  localparam state_t ST_STOP   = 3'd6;

  // Clock cycles from the first start-bit cycle to the last stop-bit cycle.
  function automatic int unsigned frame_len(input int unsigned clks_per_bit,
                                            input int unsigned data_w,
                                            input int unsigned parity_en,
                                            input int unsigned stop_bits);
    return clks_per_bit * (1 + data_w + parity_en + stop_bits);
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
module uart_baud_cnt
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  output logic bit_done_c
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  // Free-running within a bit, wraps on the boundary, held at zero while cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear_i || (cnt == CNT_MAX)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign bit_done_c = !clear_i && (cnt == CNT_MAX);

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops bytes from a sync FIFO and serialises them as UART frames on tx_o.
module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned PARITY_EN    = 0,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned RD_LAT       = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable_i,
  input  logic              empty_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              rd_en_o,
  output logic              tx_o,
  output logic              busy_o
);

  localparam int unsigned BIT_CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;
  localparam logic [BIT_CNT_W-1:0] LAST_DATA = BIT_CNT_W'(DATA_W - 1);
  localparam logic [BIT_CNT_W-1:0] LAST_STOP = BIT_CNT_W'(STOP_BITS - 1);

  // Reject parameter combinations the datapath cannot honour.
  if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
    $error("fifo_uart_tx: CLKS_PER_BIT must be 2 or more");
  end
  if (RD_LAT > 1) begin : g_bad_rd_lat
    $error("fifo_uart_tx: RD_LAT must be 0 or 1");
  end
  if ((STOP_BITS < 1) || (STOP_BITS > 2)) begin : g_bad_stop_bits
    $error("fifo_uart_tx: STOP_BITS must be 1 or 2");
  end
  if (PARITY_EN > 1) begin : g_bad_parity_en
    $error("fifo_uart_tx: PARITY_EN must be 0 or 1");
  end

  state_t                 state;
  state_t                 next_state;
  logic [DATA_W-1:0]      shreg;
  logic [DATA_W-1:0]      shreg_nxt;
  logic                   par;
  logic                   par_nxt;
  logic [BIT_CNT_W-1:0]   bit_cnt;
  logic [BIT_CNT_W-1:0]   bit_cnt_nxt;
  logic                   capture_c;
  logic                   baud_clear_c;
  logic                   bit_done_c;
  logic                   tx_nxt;
  logic                   rd_en_nxt;
  logic                   busy_nxt;

  assign capture_c    = ((state == ST_FETCH) && (RD_LAT == 0)) || (state == ST_LOAD);
  assign baud_clear_c = (state == ST_IDLE) || (state == ST_FETCH) || (state == ST_LOAD);

  uart_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_i   (baud_clear_c),
    .bit_done_c(bit_done_c)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; empty_i only matters while idle.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:   if (enable_i && !empty_i) next_state = ST_FETCH;
      ST_FETCH:  next_state = (RD_LAT == 1) ? ST_LOAD : ST_START;
      ST_LOAD:   next_state = ST_START;
      ST_START:  if (bit_done_c) next_state = ST_DATA;
      ST_DATA:   if (bit_done_c && (bit_cnt == LAST_DATA))
                   next_state = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
      ST_PARITY: if (bit_done_c) next_state = ST_STOP;
      ST_STOP:   if (bit_done_c && (bit_cnt == LAST_STOP)) next_state = ST_IDLE;
      default:   next_state = ST_IDLE;
    endcase
  end

  // Datapath next values: byte capture, LSB-first shifting, data/stop bit counting.
  always_comb begin
    shreg_nxt   = shreg;
    par_nxt     = par;
    bit_cnt_nxt = bit_cnt;
    if (capture_c) begin
      shreg_nxt   = data_i;
      par_nxt     = ^data_i;
      bit_cnt_nxt = '0;
    end else if ((state == ST_DATA) && bit_done_c) begin
      shreg_nxt   = shreg >> 1;
      bit_cnt_nxt = (bit_cnt == LAST_DATA) ? '0 : bit_cnt + BIT_CNT_W'(1);
    end else if ((state == ST_STOP) && bit_done_c) begin
      bit_cnt_nxt = (bit_cnt == LAST_STOP) ? '0 : bit_cnt + BIT_CNT_W'(1);
    end
  end

  // Output decode from the upcoming state so the registered pins line up with it.
  always_comb begin
    tx_nxt    = 1'b1;
    rd_en_nxt = 1'b0;
    busy_nxt  = (next_state != ST_IDLE);
    case (next_state)
      ST_FETCH:  rd_en_nxt = 1'b1;
      ST_START:  tx_nxt    = 1'b0;
      ST_DATA:   tx_nxt    = shreg_nxt[0];
      ST_PARITY: tx_nxt    = par_nxt;
      default:   tx_nxt    = 1'b1;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg   <= '0;
      par     <= 1'b0;
      bit_cnt <= '0;
      tx_o    <= 1'b1;
      rd_en_o <= 1'b0;
      busy_o  <= 1'b0;
    end else begin
      shreg   <= shreg_nxt;
      par     <= par_nxt;
      bit_cnt <= bit_cnt_nxt;
      tx_o    <= tx_nxt;
      rd_en_o <= rd_en_nxt;
      busy_o  <= busy_nxt;
    end
  end

endmodule
